peng_countdown_core: RTL and testbench

- Countdown timer core for the PengTimer design.
- Sits directly downstream of the 64 Hz divider and consumes its square-wave output as a time base, sampled in the system clock domain.
- Holds an MM:SS value in BCD, counts it down once per 64 base ticks and flags expiry.
- Feeds the display and buzzer logic with BCD digits, status bits, a colon-blink signal and a one-cycle alarm pulse.

---
 rtl/peng_timer_pkg.sv | 48 ++++
 rtl/peng_countdown_core_if.sv | 28 ++
 rtl/tick_sync_edge.sv | 29 ++
 rtl/peng_countdown_core.sv | 125 ++++++++++++
 tb/tb_peng_countdown_core.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/peng_timer_pkg.sv
// rtl/peng_timer_pkg.sv - shared types, constants and BCD helpers for the PengTimer countdown
// Purpose: state enum, default tick rate and two-digit BCD arithmetic/clamping.
// Ports: none (package).
package peng_timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int TICKS_PER_SEC_DEF = 64;

  // Decrement a two-digit BCD value. When the value is 00 the tens digit
  // wraps to tens_wrap, units to 9, and bit 8 (borrow-out) is set.
  function automatic logic [8:0] bcd_dec2(input logic [7:0] v, input logic [3:0] tens_wrap);
    logic [3:0] t;
    logic [3:0] u;
    logic       b;
    t = v[7:4];
    u = v[3:0];
    b = 1'b0;
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = tens_wrap;
        b = 1'b1;
      end
    end
    return {b, t, u};
  endfunction

  function automatic logic [7:0] bcd_clamp_min(input logic [7:0] v);
    return {(v[7:4] > 4'd9) ? 4'd9 : v[7:4],
            (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
  endfunction

  function automatic logic [7:0] bcd_clamp_sec(input logic [7:0] v);
    return {(v[7:4] > 4'd5) ? 4'd5 : v[7:4],
            (v[3:0] > 4'd9) ? 4'd9 : v[3:0]};
  endfunction

endpackage

// File: rtl/peng_countdown_core_if.sv
// rtl/peng_countdown_core_if.sv - command and status bundle of the countdown core
// Purpose: groups the command pulses, preset value and display/status outputs.
// Ports (signals): load, start, pause, clear, preset_min[7:0], preset_sec[7:0] (master -> slave);
//                  min_bcd[7:0], sec_bcd[7:0], running, done, alarm, blink (slave -> master).
interface peng_countdown_core_if;
  logic       load;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;
  logic       blink;

  modport master (
    output load, start, pause, clear, preset_min, preset_sec,
    input  min_bcd, sec_bcd, running, done, alarm, blink
  );

  modport slave (
    input  load, start, pause, clear, preset_min, preset_sec,
    output min_bcd, sec_bcd, running, done, alarm, blink
  );
endinterface

// File: rtl/tick_sync_edge.sv
// rtl/tick_sync_edge.sv - synchronizer and rising-edge detector for the 64 Hz time base
// Purpose: brings tick_in into the clk domain and emits a one-cycle pulse per rising edge.
// Ports: clk, rst (sync, active-high), tick_in (async square wave), tick_o (one-cycle pulse).
module tick_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both terms come from flops, so the pulse is glitch-free and one cycle wide.
  assign tick_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/peng_countdown_core.sv
// rtl/peng_countdown_core.sv - MM:SS BCD countdown timer core driven by a 64 Hz time base
// Purpose: command FSM, sub-second fraction counter and BCD time registers with expiry alarm.
// Ports: clk, rst (sync, active-high), tick_in (64 Hz square wave),
//        bus (slave modport: commands/preset in, BCD time, running, done, alarm, blink out).
module peng_countdown_core
  import peng_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_in,
  peng_countdown_core_if.slave bus
);

  localparam int             FW       = $clog2(TICKS_PER_SEC);
  localparam logic [FW-1:0]  FRAC_MAX = FW'(TICKS_PER_SEC - 1);

  state_e        state_q;
  logic [FW-1:0] frac_q;
  logic [7:0]    min_q;
  logic [7:0]    sec_q;
  logic          running_q;
  logic          done_q;
  logic          alarm_q;

  logic          tick;
  logic [8:0]    sec_dec;
  logic [8:0]    min_dec;
  logic [7:0]    min_d;
  logic [7:0]    sec_d;
  logic          time_zero;
  logic          load_ok;
  logic          start_ok;
  logic          pause_ok;

  tick_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .tick_o  (tick)
  );

  assign sec_dec = bcd_dec2(sec_q, 4'd5);
  assign min_dec = bcd_dec2(min_q, 4'd9);

  // Minutes only move on a seconds borrow; a minutes borrow would mean the
  // time was already 00:00, in which case minutes stay at 00.
  always_comb begin
    sec_d = sec_dec[7:0];
    min_d = min_q;
    if (sec_dec[8] && !min_dec[8]) begin
      min_d = min_dec[7:0];
    end
  end

  assign time_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // Acceptance per command; the if/else chain below applies clear > load > start > pause.
  assign load_ok  = bus.load  && (state_q != RUN);
  assign start_ok = bus.start && (((state_q == IDLE) && !time_zero) || (state_q == PAUSED));
  assign pause_ok = bus.pause && (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      frac_q    <= '0;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      alarm_q <= 1'b0;
      if (bus.clear) begin
        state_q   <= IDLE;
        frac_q    <= '0;
        min_q     <= 8'h00;
        sec_q     <= 8'h00;
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (load_ok) begin
        state_q   <= IDLE;
        frac_q    <= '0;
        min_q     <= bcd_clamp_min(bus.preset_min);
        sec_q     <= bcd_clamp_sec(bus.preset_sec);
        running_q <= 1'b0;
        done_q    <= 1'b0;
      end else if (start_ok) begin
        // Resuming from PAUSED keeps the partial second.
        if (state_q == IDLE) begin
          frac_q <= '0;
        end
        state_q   <= RUN;
        running_q <= 1'b1;
      end else if (pause_ok) begin
        state_q   <= PAUSED;
        running_q <= 1'b0;
      end else if ((state_q == RUN) && tick) begin
        if (frac_q != FRAC_MAX) begin
          frac_q <= frac_q + FW'(1);
        end else begin
          frac_q <= '0;
          min_q  <= min_d;
          sec_q  <= sec_d;
          if ((min_d == 8'h00) && (sec_d == 8'h00)) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
            alarm_q   <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.min_bcd = min_q;
  assign bus.sec_bcd = sec_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;
  assign bus.blink   = running_q & frac_q[FW-1];

endmodule

// File: tb/tb_peng_countdown_core.sv
// tb/tb_peng_countdown_core.sv - scoreboard bench for the countdown timer core
module tb_peng_countdown_core;

  logic clk;
  logic rst;
  logic tick_in;

  peng_countdown_core_if bus ();

  peng_countdown_core dut (
    .clk     (clk),
    .rst     (rst),
    .tick_in (tick_in),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [17:0] sb_exp[$];
  string       sb_tag[$];

  int   alarm_cnt  = 0;
  int   alarm_long = 0;
  logic alarm_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.alarm === 1'b1) begin
      alarm_cnt = alarm_cnt + 1;
      if (alarm_prev) alarm_long = alarm_long + 1;
    end
    alarm_prev = (bus.alarm === 1'b1);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] status();
    return {bus.min_bcd, bus.sec_bcd, bus.running, bus.done};
  endfunction

  function automatic logic [17:0] mk(input logic [7:0] m, input logic [7:0] s,
                                     input logic r, input logic d);
    return {m, s, r, d};
  endfunction

  task automatic sb_push(input string tag, input logic [17:0] exp);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
  endtask

  task automatic sb_pop_check();
    logic [17:0] e;
    string       t;
    if (sb_exp.size() == 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL sb_underflow: got empty queue, want an entry");
    end else begin
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      check_eq(t, {14'd0, status()}, {14'd0, e});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
      step();
      tick_in = 1'b0;
      step();
      step();
    end
  endtask

  task automatic cmd(input logic c, input logic l, input logic s, input logic p);
    bus.clear = c;
    bus.load  = l;
    bus.start = s;
    bus.pause = p;
    step();
    bus.clear = 1'b0;
    bus.load  = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
  endtask

  task automatic load_preset(input logic [7:0] m, input logic [7:0] s);
    bus.preset_min = m;
    bus.preset_sec = s;
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // 1. reset while every input is active
    rst = 1'b1;
    tick_in = 1'b1;
    bus.clear = 1'b1;
    bus.load = 1'b1;
    bus.start = 1'b1;
    bus.pause = 1'b1;
    bus.preset_min = 8'h12;
    bus.preset_sec = 8'h34;
    step();
    rst = 1'b0;
    tick_in = 1'b0;
    bus.clear = 1'b0;
    bus.load = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    sb_push("reset_status", mk(8'h00, 8'h00, 1'b0, 1'b0));
    sb_pop_check();
    check_eq("reset_alarm", {31'd0, bus.alarm}, 32'd0);
    check_eq("reset_blink", {31'd0, bus.blink}, 32'd0);
    alarm_cnt = 0;
    sb_push("idle_200_ticks", mk(8'h00, 8'h00, 1'b0, 1'b0));
    ticks(200);
    sb_pop_check();
    check_eq("idle_no_alarm", alarm_cnt, 0);

    // 2. 01:05 run to expiry
    load_preset(8'h01, 8'h05);
    sb_push("load_0105", mk(8'h01, 8'h05, 1'b0, 1'b0));
    sb_pop_check();
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("first_second", mk(8'h01, 8'h04, 1'b1, 1'b0));
    ticks(64);
    sb_pop_check();
    alarm_cnt = 0;
    alarm_long = 0;
    sb_push("before_expiry", mk(8'h00, 8'h01, 1'b1, 1'b0));
    ticks(4159 - 64);
    sb_pop_check();
    check_eq("no_early_alarm", alarm_cnt, 0);
    sb_push("expired", mk(8'h00, 8'h00, 1'b0, 1'b1));
    ticks(1);
    sb_pop_check();
    check_eq("alarm_pulses", alarm_cnt, 1);
    check_eq("alarm_width", alarm_long, 0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("start_in_done", mk(8'h00, 8'h00, 1'b0, 1'b1));
    ticks(70);
    sb_pop_check();
    check_eq("done_single_alarm", alarm_cnt, 1);

    // 3. borrow cases, blink, load ignored in RUN
    load_preset(8'h10, 8'h00);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(32);
    check_eq("blink_high", {31'd0, bus.blink}, 32'd1);
    sb_push("borrow_1000", mk(8'h09, 8'h59, 1'b1, 1'b0));
    ticks(32);
    sb_pop_check();
    check_eq("blink_low", {31'd0, bus.blink}, 32'd0);
    sb_push("load_in_run", mk(8'h09, 8'h59, 1'b1, 1'b0));
    load_preset(8'h00, 8'h10);
    sb_pop_check();
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    load_preset(8'h00, 8'h10);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("borrow_0010", mk(8'h00, 8'h09, 1'b1, 1'b0));
    ticks(64);
    sb_pop_check();

    // 4. pause holds time and fraction
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    load_preset(8'h00, 8'h03);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(30);
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
    sb_push("paused", mk(8'h00, 8'h03, 1'b0, 1'b0));
    sb_pop_check();
    check_eq("paused_blink", {31'd0, bus.blink}, 32'd0);
    sb_push("paused_100", mk(8'h00, 8'h03, 1'b0, 1'b0));
    ticks(100);
    sb_pop_check();
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    sb_push("resume_33", mk(8'h00, 8'h03, 1'b1, 1'b0));
    ticks(33);
    sb_pop_check();
    sb_push("resume_34", mk(8'h00, 8'h02, 1'b1, 1'b0));
    ticks(1);
    sb_pop_check();

    // 5. priority and illegal cases
    sb_push("clear_beats_start", mk(8'h00, 8'h00, 1'b0, 1'b0));
    cmd(1'b1, 1'b0, 1'b1, 1'b0);
    sb_pop_check();
    sb_push("start_at_zero", mk(8'h00, 8'h00, 1'b0, 1'b0));
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(2);
    sb_pop_check();
    sb_push("clamp_af_7a", mk(8'h99, 8'h59, 1'b0, 1'b0));
    load_preset(8'hAF, 8'h7A);
    sb_pop_check();
    sb_push("clamp_3c_60", mk(8'h39, 8'h50, 1'b0, 1'b0));
    load_preset(8'h3C, 8'h60);
    sb_pop_check();

    // 6. reset mid-run
    load_preset(8'h00, 8'h02);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(70);
    alarm_cnt = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_push("midrun_reset", mk(8'h00, 8'h00, 1'b0, 1'b0));
    sb_pop_check();
    check_eq("midrun_reset_blink", {31'd0, bus.blink}, 32'd0);
    sb_push("after_reset_idle", mk(8'h00, 8'h00, 1'b0, 1'b0));
    ticks(150);
    sb_pop_check();
    check_eq("no_residual_alarm", alarm_cnt, 0);
    check_eq("sb_drained", sb_exp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
